controle_servo_multi_rampa: RTL and testbench



---
 rtl/servo_pkg.sv | 14 +
 rtl/canal_servo_rampa.sv | 69 ++++++
 rtl/controle_servo_multi_rampa.sv | 67 ++++++
 tb/tb_controle_servo_multi_rampa.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - default servo timing constants and position-to-width conversion
package servo_pkg;

    localparam int CICLOS_PERIODO_PADRAO = 1000000;
    localparam int LARG_MIN_PADRAO       = 35000;
    localparam int PASSO_LARGURA_PADRAO  = 2675;
    localparam int POS_MAX_PADRAO        = 28;
    localparam int POS_INICIAL_PADRAO    = 14;

    function automatic int largura_da_posicao(input int pos, input int larg_min, input int passo);
        return larg_min + pos * passo;
    endfunction

endpackage

// File: rtl/canal_servo_rampa.sv
// rtl/canal_servo_rampa.sv - one servo channel: target clamp, per-period ramp, PWM compare
module canal_servo_rampa
    import servo_pkg::*;
#(
    parameter int LARG_POS      = 5,
    parameter int LARG_CONT     = 20,
    parameter int LARG_MIN      = LARG_MIN_PADRAO,
    parameter int PASSO_LARGURA = PASSO_LARGURA_PADRAO,
    parameter int POS_MAX       = POS_MAX_PADRAO,
    parameter int POS_INICIAL   = POS_INICIAL_PADRAO,
    parameter int PASSO_RAMPA   = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [LARG_CONT-1:0] contador,
    input  logic                 fim_periodo,
    input  logic                 carrega,
    input  logic [LARG_POS-1:0]  posicao,
    output logic                 controle,
    output logic                 em_movimento,
    output logic [LARG_POS-1:0]  atual
);

    localparam logic [LARG_POS-1:0]  POS_MAX_C = LARG_POS'(POS_MAX);
    localparam logic [LARG_POS-1:0]  POS_INI_C = LARG_POS'(POS_INICIAL);
    localparam logic [LARG_POS-1:0]  PASSO_C   = LARG_POS'(PASSO_RAMPA);
    localparam logic [LARG_CONT-1:0] LARG_INI  =
        LARG_CONT'(largura_da_posicao(POS_INICIAL, LARG_MIN, PASSO_LARGURA));

    logic [LARG_POS-1:0]  alvo;
    logic [LARG_POS-1:0]  atual_prox;
    logic [LARG_POS-1:0]  diferenca;
    logic [LARG_CONT-1:0] largura;

    // A zero step means "jump": the default of atual_prox = alvo covers it.
    always_comb begin
        atual_prox = alvo;
        diferenca  = '0;
        if (alvo > atual) begin
            diferenca = alvo - atual;
            if (PASSO_RAMPA != 0 && diferenca > PASSO_C)
                atual_prox = atual + PASSO_C;
        end else begin
            diferenca = atual - alvo;
            if (PASSO_RAMPA != 0 && diferenca > PASSO_C)
                atual_prox = atual - PASSO_C;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alvo    <= POS_INI_C;
            atual   <= POS_INI_C;
            largura <= LARG_INI;
        end else begin
            if (carrega)
                alvo <= (posicao > POS_MAX_C) ? POS_MAX_C : posicao;
            // Width only moves at the boundary so the pulse in flight is never cut or stretched.
            if (fim_periodo) begin
                atual   <= atual_prox;
                largura <= LARG_CONT'(largura_da_posicao(int'(atual_prox), LARG_MIN, PASSO_LARGURA));
            end
        end
    end

    assign controle     = !reset && (contador < largura);
    assign em_movimento = (atual != alvo);

endmodule

// File: rtl/controle_servo_multi_rampa.sv
// rtl/controle_servo_multi_rampa.sv - multi-channel servo PWM with shared period counter
module controle_servo_multi_rampa
    import servo_pkg::*;
#(
    parameter int N_CANAIS       = 2,
    parameter int LARG_POS       = 5,
    parameter int CICLOS_PERIODO = CICLOS_PERIODO_PADRAO,
    parameter int LARG_MIN       = LARG_MIN_PADRAO,
    parameter int PASSO_LARGURA  = PASSO_LARGURA_PADRAO,
    parameter int POS_MAX        = POS_MAX_PADRAO,
    parameter int POS_INICIAL    = POS_INICIAL_PADRAO,
    parameter int PASSO_RAMPA    = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_CANAIS*LARG_POS-1:0] posicao,
    input  logic [N_CANAIS-1:0]          carrega,
    output logic [N_CANAIS-1:0]          controle,
    output logic [N_CANAIS-1:0]          em_movimento,
    output logic                         fim_periodo,
    output logic [N_CANAIS*LARG_POS-1:0] db_posicao,
    output logic                         db_reset
);

    localparam int LARG_CONT = $clog2(CICLOS_PERIODO);
    localparam logic [LARG_CONT-1:0] ULTIMO = LARG_CONT'(CICLOS_PERIODO - 1);

    if (LARG_MIN + POS_MAX * PASSO_LARGURA >= CICLOS_PERIODO || POS_MAX >= 2 ** LARG_POS
        || POS_INICIAL > POS_MAX) begin : g_parametros_invalidos
        $error("controle_servo_multi_rampa: widest pulse must fit in the period and POS_MAX in LARG_POS bits");
    end

    logic [LARG_CONT-1:0] contador;

    always_ff @(posedge clock) begin
        if (reset || contador == ULTIMO)
            contador <= '0;
        else
            contador <= contador + LARG_CONT'(1);
    end

    assign fim_periodo = (contador == ULTIMO);
    assign db_reset    = reset;

    for (genvar i = 0; i < N_CANAIS; i++) begin : g_canal
        canal_servo_rampa #(
            .LARG_POS      (LARG_POS),
            .LARG_CONT     (LARG_CONT),
            .LARG_MIN      (LARG_MIN),
            .PASSO_LARGURA (PASSO_LARGURA),
            .POS_MAX       (POS_MAX),
            .POS_INICIAL   (POS_INICIAL),
            .PASSO_RAMPA   (PASSO_RAMPA)
        ) u_canal (
            .clock        (clock),
            .reset        (reset),
            .contador     (contador),
            .fim_periodo  (fim_periodo),
            .carrega      (carrega[i]),
            .posicao      (posicao[i*LARG_POS +: LARG_POS]),
            .controle     (controle[i]),
            .em_movimento (em_movimento[i]),
            .atual        (db_posicao[i*LARG_POS +: LARG_POS])
        );
    end

endmodule

// File: tb/tb_controle_servo_multi_rampa.sv
// tb/tb_controle_servo_multi_rampa.sv - directed bench for the ramped multi-channel servo controller
module tb_controle_servo_multi_rampa;

    localparam int N  = 2;
    localparam int LP = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N*LP-1:0] posicao = '0, posicao_b = '0;
    logic [N-1:0]  carrega = '0, carrega_b = '0;
    logic [N-1:0]  controle, em_movimento, controle_b, em_b;
    logic          fim_periodo, fim_b, db_reset, db_reset_b;
    logic [N*LP-1:0] db_posicao, db_posicao_b;

    int total = 0;
    int bad   = 0;
    int w0, w1, wb0, wb1, nfim, nfim_b;
    logic ult_fim;

    always #5 clock = ~clock;

    controle_servo_multi_rampa #(
        .N_CANAIS(2), .LARG_POS(5), .CICLOS_PERIODO(100), .LARG_MIN(10),
        .PASSO_LARGURA(3), .POS_MAX(28), .POS_INICIAL(14), .PASSO_RAMPA(1)
    ) u_dut (
        .clock(clock), .reset(reset), .posicao(posicao), .carrega(carrega),
        .controle(controle), .em_movimento(em_movimento), .fim_periodo(fim_periodo),
        .db_posicao(db_posicao), .db_reset(db_reset)
    );

    controle_servo_multi_rampa #(
        .N_CANAIS(2), .LARG_POS(5), .CICLOS_PERIODO(100), .LARG_MIN(10),
        .PASSO_LARGURA(3), .POS_MAX(28), .POS_INICIAL(14), .PASSO_RAMPA(0)
    ) u_dut_salto (
        .clock(clock), .reset(reset), .posicao(posicao_b), .carrega(carrega_b),
        .controle(controle_b), .em_movimento(em_b), .fim_periodo(fim_b),
        .db_posicao(db_posicao_b), .db_reset(db_reset_b)
    );

    task automatic check(input string tag, input int obs, input int esp);
        total++;
        if (obs != esp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
        end
    endtask

    task automatic zerar();
        w0 = 0; w1 = 0; wb0 = 0; wb1 = 0; nfim = 0; nfim_b = 0; ult_fim = 1'b0;
    endtask

    // Samples the current cycle, then steps to the next falling edge, n times.
    task automatic medir(input int n);
        for (int i = 0; i < n; i++) begin
            w0      += int'(controle[0]);
            w1      += int'(controle[1]);
            wb0     += int'(controle_b[0]);
            wb1     += int'(controle_b[1]);
            nfim    += int'(fim_periodo);
            nfim_b  += int'(fim_b);
            ult_fim  = fim_periodo;
            @(negedge clock);
        end
    endtask

    task automatic check_fim(input string tag);
        check(tag, (nfim == 1 && ult_fim) ? 1 : 0, 1);
    endtask

    // Leaves the caller on the falling edge where contador = 0.
    task automatic esperar_fim();
        int n = 0;
        while (!fim_periodo && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("timeout_fim", int'(fim_periodo), 1);
        @(negedge clock);
    endtask

    initial begin
        // 1: reset state, then three idle periods
        repeat (3) @(negedge clock);
        check("rst_controle", int'(controle), 0);
        check("rst_em", int'(em_movimento), 0);
        check("rst_fim", int'(fim_periodo), 0);
        check("rst_db_reset", int'(db_reset), 1);
        check("rst_db_pos", int'(db_posicao), 14 * 32 + 14);
        reset = 1'b0;
        esperar_fim();
        for (int k = 0; k < 3; k++) begin
            zerar();
            check("t1_pos", int'(db_posicao), 14 * 32 + 14);
            medir(100);
            check("t1_w0", w0, 52);
            check("t1_w1", w1, 52);
            check_fim("t1_fim");
        end

        // 2: mid-period load of ch0 = 18
        zerar();
        medir(40);
        posicao = 10'd18;
        carrega = 2'b01;
        medir(1);
        carrega = 2'b00;
        check("t2_em_load", int'(em_movimento), 1);
        medir(59);
        check("t2_inflight_w0", w0, 52);
        check_fim("t2_fim0");
        for (int k = 0; k < 4; k++) begin
            zerar();
            check("t2_em", int'(em_movimento[0]), (k < 3) ? 1 : 0);
            check("t2_pos0", int'(db_posicao[4:0]), 15 + k);
            medir(100);
            check("t2_w0", w0, 55 + 3 * k);
            check("t2_w1", w1, 52);
            check_fim("t2_fim");
        end

        // 3: ch1 loaded out of range, clamps to 28 and ramps
        zerar();
        posicao = {5'd31, 5'd0};
        carrega = 2'b10;
        medir(1);
        carrega = 2'b00;
        check("t3_em_load", int'(em_movimento), 2);
        medir(99);
        check("t3_inflight_w0", w0, 64);
        check("t3_inflight_w1", w1, 52);
        for (int k = 0; k < 14; k++) begin
            zerar();
            check("t3_em1", int'(em_movimento[1]), (k < 13) ? 1 : 0);
            medir(100);
            check("t3_w1", w1, 55 + 3 * k);
            check("t3_w0", w0, 64);
        end
        check("t3_pos1_clamp", int'(db_posicao[9:5]), 28);

        // 6: reset in the middle of a ramp
        zerar();
        posicao = 10'd0;
        carrega = 2'b01;
        medir(1);
        carrega = 2'b00;
        medir(99);
        check("t6_w0_before", w0, 64);
        zerar();
        medir(40);
        check("t6_w0_partial", w0, 40);
        reset = 1'b1;
        #1;
        check("t6_controle_rst", int'(controle), 0);
        check("t6_controle_b_rst", int'(controle_b), 0);
        @(negedge clock);
        check("t6_controle_rst2", int'(controle), 0);
        check("t6_db_reset", int'(db_reset), 1);
        check("t6_db_reset_b", int'(db_reset_b), 1);
        check("t6_pos", int'(db_posicao), 14 * 32 + 14);
        check("t6_pos_b", int'(db_posicao_b), 14 * 32 + 14);
        check("t6_em", int'(em_movimento), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        zerar();
        medir(100);
        check("t6_w0", w0, 52);
        check("t6_w1", w1, 52);
        check("t6_wb0", wb0, 52);
        check("t6_wb1", wb1, 52);
        check_fim("t6_fim");
        check("t6_fim_b", nfim_b, 1);

        // 4: load on the fim_periodo cycle, ch0 14 -> 10
        zerar();
        medir(99);
        check("t4_fim_now", int'(fim_periodo), 1);
        posicao = 10'd10;
        carrega = 2'b01;
        medir(1);
        carrega = 2'b00;
        check("t4_inflight_w0", w0, 52);
        for (int k = 0; k < 5; k++) begin
            zerar();
            check("t4_em", int'(em_movimento[0]), (k < 4) ? 1 : 0);
            check("t4_pos0", int'(db_posicao[4:0]), (k == 0) ? 14 : 14 - k);
            medir(100);
            check("t4_w0", w0, (k == 0) ? 52 : 52 - 3 * k);
        end

        // 5: jump instance, ch0 -> 0
        zerar();
        medir(40);
        posicao_b = 10'd0;
        carrega_b = 2'b01;
        medir(1);
        carrega_b = 2'b00;
        check("t5_em_load", int'(em_b), 1);
        medir(59);
        check("t5_inflight_wb0", wb0, 52);
        zerar();
        check("t5_em_after", int'(em_b), 0);
        check("t5_pos_b0", int'(db_posicao_b[4:0]), 0);
        medir(100);
        check("t5_wb0", wb0, 10);
        check("t5_wb1", wb1, 52);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
